bus_arbiter: RTL and testbench

Parametrised multi-master bus arbiter for the minx system bus. It generalises the two-master CPU/PRC `bus_request`/`bus_ack` handover to N masters. Master 0 (the CPU) is the park master and owns the bus whenever no other master holds a grant. Arbitration is fixed-priority or round-robin, with an optional hold limit that asks a long-running owner to release the bus. The arbiter registers ownership and drives the shared address, data and command lines seen by the LCD, PRC, timer and IRQ register blocks.

---
 rtl/bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Multi-master arbiter for the minx system bus: master 0 parks on the bus, masters 1..N-1
// win it by fixed priority or round-robin, with an optional hold limit and a muxed shared bus.
module bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RR_MODE     = 0,
  parameter int unsigned MAX_HOLD    = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_address,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_data,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [2*NUM_MASTERS-1:0]          m_bus_status,
  output logic [NUM_MASTERS-1:0]            ack,
  output logic [NUM_MASTERS-1:0]            preempt,
  output logic [$clog2(NUM_MASTERS)-1:0]    owner,
  output logic [ADDR_W-1:0]                 address_out,
  output logic [DATA_W-1:0]                 data_out,
  output logic                              read,
  output logic                              write,
  output logic [1:0]                        bus_status
);

  localparam int unsigned OWN_W  = $clog2(NUM_MASTERS);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 2);
  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

  typedef enum logic [1:0] {
    ST_PARK,
    ST_GAP,
    ST_GRANT
  } state_t;

  state_t                  state_q, state_d;
  logic [OWN_W-1:0]        owner_q, owner_d;
  logic [OWN_W-1:0]        next_q, next_d;
  logic [OWN_W-1:0]        ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0]  ack_q, ack_d;
  logic [NUM_MASTERS-1:0]  pre_q, pre_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;

  logic [NUM_MASTERS-1:0]  sel;
  logic [NUM_MASTERS-1:0]  others;
  logic                    any_hi;
  logic                    req_own;
  logic                    cpu_busy;
  logic                    hold_hit;

  // Winner among masters 1..N-1: lowest index, or first index after ptr wrapping N-1 -> 1.
  function automatic logic [OWN_W-1:0] pick(input logic [NUM_MASTERS-1:0] r,
                                            input logic [OWN_W-1:0]       ptr);
    logic [OWN_W-1:0]       win;
    logic                   found;
    logic [NUM_MASTERS-1:0] r_sh;
    int unsigned            cand;
    win   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off < NUM_MASTERS; off++) begin
      if (RR_MODE != 0) begin
        cand = 32'(ptr) + off;
        if (cand >= NUM_MASTERS) cand = cand - (NUM_MASTERS - 1);
      end else begin
        cand = off;
      end
      r_sh = r >> cand;
      if (!found && r_sh[0]) begin
        win   = OWN_W'(cand);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign sel      = NUM_MASTERS'(1) << owner_q;
  assign others   = req & ~sel & ~NUM_MASTERS'(1);
  assign any_hi   = |(req & ~NUM_MASTERS'(1));
  assign req_own  = |(req & ack_q);
  assign cpu_busy = m_read[0] | m_write[0];
  assign hold_hit = (MAX_HOLD != 0) && ((32'(hold_q) + 32'd1) > MAX_HOLD);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    next_d  = next_q;
    ptr_d   = ptr_q;
    ack_d   = ack_q;
    pre_d   = pre_q;
    hold_d  = hold_q;
    case (state_q)
      ST_PARK: begin
        if (any_hi && !cpu_busy) begin
          state_d = ST_GAP;
          next_d  = pick(req, ptr_q);
          ack_d   = '0;
        end
      end
      ST_GAP: begin
        if (next_q != '0) begin
          state_d = ST_GRANT;
          owner_d = next_q;
          ptr_d   = next_q;
          ack_d   = NUM_MASTERS'(1) << next_q;
          hold_d  = HOLD_W'(1);
          pre_d   = '0;
        end else begin
          state_d = ST_PARK;
          owner_d = '0;
          ack_d   = NUM_MASTERS'(1);
        end
      end
      ST_GRANT: begin
        if (!req_own) begin
          state_d = ST_GAP;
          next_d  = pick(req, ptr_q);
          ack_d   = '0;
          pre_d   = '0;
          hold_d  = '0;
        end else begin
          if (hold_q != HOLD_SAT) hold_d = hold_q + HOLD_W'(1);
          // Preempt is sticky until the owner lets go.
          if (hold_hit && (others != '0)) pre_d = ack_q;
        end
      end
      default: begin
        state_d = ST_PARK;
        owner_d = '0;
        ack_d   = NUM_MASTERS'(1);
        pre_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_PARK;
      owner_q <= '0;
      next_q  <= '0;
      ptr_q   <= '0;
      ack_q   <= NUM_MASTERS'(1);
      pre_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      next_q  <= next_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
    end
  end

  assign ack     = ack_q;
  assign preempt = pre_q;
  assign owner   = owner_q;

  // Shared bus follows the registered owner; the dead cycle drives an idle bus.
  always_comb begin
    address_out = '0;
    data_out    = '0;
    read        = 1'b0;
    write       = 1'b0;
    bus_status  = 2'b00;
    if (state_q != ST_GAP) begin
      address_out = ADDR_W'(m_address >> (32'(owner_q) * ADDR_W));
      data_out    = DATA_W'(m_data >> (32'(owner_q) * DATA_W));
      read        = |(m_read & sel);
      write       = |(m_write & sel);
      bus_status  = 2'(m_bus_status >> (32'(owner_q) * 2));
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three configurations on shared stimulus, checked each cycle against
// a cycle-level reference model, plus directed literal expectations for the key handovers.
`timescale 1ns/1ps
module tb_bus_arbiter;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] rd = '0;
  logic [3:0] wr = '0;
  logic [4*AW-1:0] addr = '0;
  logic [4*DW-1:0] data = '0;
  logic [7:0] st = '0;

  logic [3:0] ack0, pre0, ack1, pre1;
  logic [1:0] own0, own1;
  logic [1:0] ack2, pre2;
  logic [0:0] own2;
  logic [AW-1:0] ao0, ao1, ao2;
  logic [DW-1:0] do0, do1, do2;
  logic rdo0, rdo1, rdo2, wro0, wro1, wro2;
  logic [1:0] bs0, bs1, bs2;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int exp_ord [6] = '{1, 2, 3, 1, 2, 3};

  // u0: fixed priority with hold limit 8; u1: round-robin with hold limit 3; u2: two masters.
  bus_arbiter #(.NUM_MASTERS(4), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_HOLD(8)) u0 (
    .clk(clk), .reset(reset), .req(req), .m_address(addr), .m_data(data), .m_read(rd),
    .m_write(wr), .m_bus_status(st), .ack(ack0), .preempt(pre0), .owner(own0),
    .address_out(ao0), .data_out(do0), .read(rdo0), .write(wro0), .bus_status(bs0));
  bus_arbiter #(.NUM_MASTERS(4), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .MAX_HOLD(3)) u1 (
    .clk(clk), .reset(reset), .req(req), .m_address(addr), .m_data(data), .m_read(rd),
    .m_write(wr), .m_bus_status(st), .ack(ack1), .preempt(pre1), .owner(own1),
    .address_out(ao1), .data_out(do1), .read(rdo1), .write(wro1), .bus_status(bs1));
  bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_HOLD(0)) u2 (
    .clk(clk), .reset(reset), .req(req[1:0]), .m_address(addr[2*AW-1:0]),
    .m_data(data[2*DW-1:0]), .m_read(rd[1:0]), .m_write(wr[1:0]), .m_bus_status(st[3:0]),
    .ack(ack2), .preempt(pre2), .owner(own2), .address_out(ao2), .data_out(do2),
    .read(rdo2), .write(wro2), .bus_status(bs2));

  always #5 clk = ~clk;

  function automatic int n_of(input int u);
    return (u == 2) ? 2 : 4;
  endfunction
  function automatic bit rr_of(input int u);
    return (u == 1);
  endfunction
  function automatic int mh_of(input int u);
    return (u == 0) ? 8 : ((u == 1) ? 3 : 0);
  endfunction

  // Reference model: m_own = -1 for the dead cycle, 0 parked, k>0 granted to master k.
  int m_own [NI];
  int m_next [NI];
  int m_hold [NI];
  int m_ptr [NI];
  bit m_pre [NI];

  function automatic int pick(input int u, input logic [3:0] r);
    int n;
    int c;
    n = n_of(u);
    for (int off = 1; off < n; off++) begin
      if (rr_of(u)) c = (m_ptr[u] - 1 + off) % (n - 1) + 1;
      else c = off;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < NI; u++) begin
      m_own[u] = 0; m_next[u] = 0; m_hold[u] = 0; m_ptr[u] = 0; m_pre[u] = 1'b0;
    end
  endtask

  task automatic model_step(input int u);
    logic [3:0] r;
    logic [3:0] oth;
    int k;
    r = (n_of(u) == 2) ? (req & 4'b0011) : req;
    k = m_own[u];
    if (k == 0) begin
      if (r[3:1] != 3'b000 && !rd[0] && !wr[0]) begin
        m_next[u] = pick(u, r);
        m_own[u] = -1;
      end
    end else if (k < 0) begin
      if (m_next[u] != 0) begin
        m_own[u] = m_next[u]; m_ptr[u] = m_next[u]; m_hold[u] = 1; m_pre[u] = 1'b0;
      end else begin
        m_own[u] = 0;
      end
    end else if (!r[k]) begin
      m_next[u] = pick(u, r);
      m_own[u] = -1; m_pre[u] = 1'b0; m_hold[u] = 0;
    end else begin
      oth = r; oth[0] = 1'b0; oth[k] = 1'b0;
      if (mh_of(u) > 0 && m_hold[u] >= mh_of(u) && oth != 4'b0000) m_pre[u] = 1'b1;
      if (m_hold[u] < 1000) m_hold[u] = m_hold[u] + 1;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else for (int u = 0; u < NI; u++) model_step(u);
  end

  task automatic check(input string name, input int u, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d got=%0h want=%0h t=%0t", name, u, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < NI; u++) begin
        logic [63:0] a_ack, a_pre, a_own, a_addr, a_data, a_rd, a_wr, a_bs;
        logic [63:0] e_ack, e_pre, e_addr, e_data, e_rd, e_wr, e_bs;
        int o;
        case (u)
          0: begin a_ack = 64'(ack0); a_pre = 64'(pre0); a_own = 64'(own0); a_addr = 64'(ao0);
                   a_data = 64'(do0); a_rd = 64'(rdo0); a_wr = 64'(wro0); a_bs = 64'(bs0); end
          1: begin a_ack = 64'(ack1); a_pre = 64'(pre1); a_own = 64'(own1); a_addr = 64'(ao1);
                   a_data = 64'(do1); a_rd = 64'(rdo1); a_wr = 64'(wro1); a_bs = 64'(bs1); end
          default: begin a_ack = 64'(ack2); a_pre = 64'(pre2); a_own = 64'(own2); a_addr = 64'(ao2);
                   a_data = 64'(do2); a_rd = 64'(rdo2); a_wr = 64'(wro2); a_bs = 64'(bs2); end
        endcase
        o = m_own[u];
        e_ack = (o < 0) ? 64'd0 : (64'd1 << o);
        e_pre = (o > 0 && m_pre[u]) ? (64'd1 << o) : 64'd0;
        if (o < 0) begin
          e_addr = '0; e_data = '0; e_rd = '0; e_wr = '0; e_bs = '0;
        end else begin
          e_addr = 64'(addr[o*AW +: AW]);
          e_data = 64'(data[o*DW +: DW]);
          e_rd = 64'(rd[o]);
          e_wr = 64'(wr[o]);
          e_bs = 64'(st[2*o +: 2]);
        end
        check("ack", u, a_ack, e_ack);
        check("preempt", u, a_pre, e_pre);
        if (o >= 0) check("owner", u, a_own, 64'(o));
        check("address_out", u, a_addr, e_addr);
        check("data_out", u, a_data, e_data);
        check("read", u, a_rd, e_rd);
        check("write", u, a_wr, e_wr);
        check("bus_status", u, a_bs, e_bs);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges; outputs must return to reset values with no clock edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_ack", 0, 64'(ack0), 64'h1);
    check("rst_owner", 0, 64'(own0), 64'h0);
    check("rst_preempt", 0, 64'(pre0), 64'h0);
    check("rst_ack", 1, 64'(ack1), 64'h1);
    check("rst_ack", 2, 64'(ack2), 64'h1);
    @(posedge clk);
    #3 reset = 1'b1;
    tick();
  endtask

  function automatic int grant_idx(input logic [3:0] a);
    for (int i = 1; i < 4; i++) if (a == (4'b0001 << i)) return i;
    return 0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) addr[i*AW +: AW] = 24'h100000 * (i + 1) + 24'h000A5;
    data = 32'h44332211;
    st = 8'b10_01_11_00;
    do_reset();

    // Single request, two-cycle handover and release.
    addr[AW +: AW] = 24'hABC123;
    req = 4'b0010;
    tick(); check("a_gap", 2, 64'(ack2), 64'h0);
            check("a_gap", 0, 64'(ack0), 64'h0);
    tick(); check("a_grant", 2, 64'(ack2), 64'h2);
            check("a_owner", 2, 64'(own2), 64'h1);
            check("a_addr", 2, 64'(ao2), 64'hABC123);
            check("a_grant", 0, 64'(ack0), 64'h2);
            check("a_grant", 1, 64'(ack1), 64'h2);
    repeat (5) tick();
    req = 4'b0000;
    tick(); check("a_rel_gap", 2, 64'(ack2), 64'h0);
    tick(); check("a_park", 2, 64'(ack2), 64'h1);
            check("a_park_own", 2, 64'(own2), 64'h0);

    // CPU busy: handover deferred while master 0 strobes.
    rd[0] = 1'b1;
    req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick(); check("b_defer", 2, 64'(ack2), 64'h1);
    end
    rd[0] = 1'b0;
    tick(); check("b_gap", 2, 64'(ack2), 64'h0);
    tick(); check("b_grant", 2, 64'(ack2), 64'h2);
    req = 4'b0000;
    tick(); tick();

    // Fixed priority: 1, then 2, then 3 with one gap between each.
    req = 4'b1110;
    tick();
    tick(); check("c_first", 0, 64'(ack0), 64'h2);
    repeat (2) tick();
    req[1] = 1'b0;
    tick(); check("c_gap1", 0, 64'(ack0), 64'h0);
    tick(); check("c_second", 0, 64'(ack0), 64'h4);
    repeat (2) tick();
    req[2] = 1'b0;
    tick(); check("c_gap2", 0, 64'(ack0), 64'h0);
    tick(); check("c_third", 0, 64'(ack0), 64'h8);
    req[3] = 1'b0;
    tick();
    tick(); check("c_park", 0, 64'(ack0), 64'h1);

    // Round-robin: continuous requesters each holding four cycles.
    do_reset();
    req = 4'b1110;
    for (int g = 0; g < 6; g++) begin
      int k;
      int waited;
      k = 0;
      waited = 0;
      while (k == 0 && waited < 20) begin
        tick();
        waited++;
        k = grant_idx(ack1);
      end
      check("rr_order", 1, 64'(k), 64'(exp_ord[g]));
      if (k == 0) break;
      repeat (3) tick();
      req[k] = 1'b0;
      tick(); check("rr_gap", 1, 64'(ack1), 64'h0);
      req[k] = 1'b1;
    end
    req = 4'b0000;
    repeat (3) tick();

    // Hold limit: preempt rises after eight grant cycles with master 2 waiting.
    do_reset();
    req = 4'b0110;
    tick();
    tick(); check("e_grant", 0, 64'(ack0), 64'h2);
    repeat (7) tick();
    check("e_pre_early", 0, 64'(pre0), 64'h0);
    tick(); check("e_pre_rise", 0, 64'(pre0), 64'h2);
    repeat (3) tick();
    check("e_pre_hold", 0, 64'(pre0), 64'h2);
    req[1] = 1'b0;
    tick(); check("e_gap", 0, 64'(ack0), 64'h0);
            check("e_pre_clr", 0, 64'(pre0), 64'h0);
    tick(); check("e_next", 0, 64'(ack0), 64'h4);
    req = 4'b0000;
    repeat (3) tick();

    // Reset in the middle of a grant, request still high afterwards.
    req = 4'b0010;
    tick();
    tick(); check("f_grant", 0, 64'(ack0), 64'h2);
    do_reset();
    check("f_gap", 0, 64'(ack0), 64'h0);
    tick(); check("f_grant2", 0, 64'(ack0), 64'h2);
            check("f_owner2", 0, 64'(own0), 64'h1);
    req = 4'b0000;
    repeat (3) tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      rd[0] = ($urandom_range(0, 3) == 0);
      wr[0] = !rd[0] && ($urandom_range(0, 4) == 0);
      rd[3:1] = 3'($urandom);
      wr[3:1] = 3'($urandom);
      addr = {$urandom, $urandom, $urandom};
      data = $urandom;
      st = 8'($urandom);
      if (c == 1500) do_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
